// File: rtl/mips_cpu_fetch_pc_if.sv
// Fetch-PC bus: redirect requests in, fetch address and status out.
// The fault signal exists only when PC_ALIGN_CHECK_EN is defined.
interface mips_cpu_fetch_pc_if;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_address;
    logic        delay_slot;
    logic [31:0] link_address;
    logic        active;
`ifdef PC_ALIGN_CHECK_EN
    logic        fault;
`endif

    modport master (
        input  redirect_valid,
        input  redirect_target,
        output instr_address,
        output delay_slot,
        output link_address,
`ifdef PC_ALIGN_CHECK_EN
        output fault,
`endif
        output active
    );

    modport slave (
        output redirect_valid,
        output redirect_target,
        input  instr_address,
        input  delay_slot,
        input  link_address,
`ifdef PC_ALIGN_CHECK_EN
        input  fault,
`endif
        input  active
    );
endinterface

// File: rtl/mips_cpu_fetch_pc.sv
// MIPS fetch program counter with one branch delay slot and halt-on-zero.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fault and halt.
module mips_cpu_fetch_pc (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_enable,
    mips_cpu_fetch_pc_if.master        fetch_io
);

    typedef enum logic [1:0] {StRun, StDelay, StHalted} state_e;

    localparam logic [31:0] ResetVector = 32'hBFC0_0000;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pending_q;
    logic        active_q;
    logic        delay_slot_q;
    logic [31:0] pc_inc;
    logic [31:0] capture_target;
    logic        misaligned;

    assign pc_inc = pc_q + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q;

    assign capture_target = fetch_io.redirect_target;
    assign misaligned     = fetch_io.redirect_target[1:0] != 2'b00;
    assign fetch_io.fault = fault_q;
`else
    assign capture_target = {fetch_io.redirect_target[31:2], 2'b00};
    assign misaligned     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= ResetVector;
            pending_q    <= 32'd0;
            active_q     <= 1'b1;
            delay_slot_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else if (clk_enable) begin
            unique case (state_q)
                StRun: begin
                    // Wrapping onto address zero halts even if a redirect is pending.
                    if (pc_inc == 32'd0) begin
                        state_q      <= StHalted;
                        pc_q         <= 32'd0;
                        active_q     <= 1'b0;
                        delay_slot_q <= 1'b0;
                    end else begin
                        pc_q <= pc_inc;
                        if (fetch_io.redirect_valid) begin
                            state_q      <= StDelay;
                            pending_q    <= capture_target;
                            delay_slot_q <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                            if (misaligned) fault_q <= 1'b1;
`endif
                        end
                    end
                end
                StDelay: begin
                    // Redirects seen in the delay slot are deliberately dropped.
                    if (pending_q == 32'd0 || misaligned_pending(pending_q)) begin
                        state_q      <= StHalted;
                        pc_q         <= 32'd0;
                        active_q     <= 1'b0;
                        delay_slot_q <= 1'b0;
                    end else begin
                        state_q      <= StRun;
                        pc_q         <= pending_q;
                        delay_slot_q <= 1'b0;
                    end
                end
                StHalted: begin
                    pc_q         <= 32'd0;
                    active_q     <= 1'b0;
                    delay_slot_q <= 1'b0;
                end
                default: begin
                    state_q      <= StHalted;
                    pc_q         <= 32'd0;
                    active_q     <= 1'b0;
                    delay_slot_q <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic misaligned_pending(input logic [31:0] target);
`ifdef PC_ALIGN_CHECK_EN
        return target[1:0] != 2'b00;
`else
        return 1'b0 & target[0];
`endif
    endfunction

    logic unused_misaligned;
    assign unused_misaligned = misaligned;

    assign fetch_io.instr_address = pc_q;
    assign fetch_io.delay_slot    = delay_slot_q;
    assign fetch_io.active        = active_q;
    assign fetch_io.link_address  = pc_q + 32'd8;

endmodule

// File: tb/tb_mips_cpu_fetch_pc.sv
// Scoreboard bench for mips_cpu_fetch_pc: stimulus pushes expected state, monitor compares.
`timescale 1ns/1ps
module tb_mips_cpu_fetch_pc;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;

    mips_cpu_fetch_pc_if bus ();

    mips_cpu_fetch_pc dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .fetch_io   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        ds;
        logic        act;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
        end
    endfunction

    int mon_idx = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            mon_idx++;
            chk("instr_address", mon_idx, bus.instr_address, e.addr);
            chk("delay_slot", mon_idx, {31'd0, bus.delay_slot}, {31'd0, e.ds});
            chk("active", mon_idx, {31'd0, bus.active}, {31'd0, e.act});
            chk("link_address", mon_idx, bus.link_address, e.addr + 32'd8);
`ifdef PC_ALIGN_CHECK_EN
            chk("fault", mon_idx, {31'd0, bus.fault}, {31'd0, e.flt});
`endif
        end
    end

    task automatic step(input logic rst, input logic en, input logic rv,
                        input logic [31:0] tgt, input logic [31:0] ea,
                        input logic eds, input logic eact, input logic eflt);
        exp_t e;
        reset               = rst;
        clk_enable          = en;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        @(posedge clk);
        e.addr = ea;
        e.ds   = eds;
        e.act  = eact;
        e.flt  = eflt;
        exp_q.push_back(e);
        n_step++;
        #1;
    endtask

    initial begin
        logic [31:0] flt_addr;
        logic        flt_ds, flt_act, flt_flag;
        reset = 1'b1;
        clk_enable = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;

        // Reset then sequential fetch.
        step(1, 0, 0, 32'd0,        32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0004, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0008, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_000C, 0, 1, 0);

        // Taken branch from the reset vector, then jr $0 into halt.
        step(1, 1, 0, 32'd0,        32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 1, 32'hBFC0_0010, 32'hBFC0_0004, 1, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0010, 0, 1, 0);
        step(0, 1, 1, 32'd0,        32'hBFC0_0014, 1, 1, 0);
        step(0, 1, 0, 32'd0,        32'h0000_0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 3) != 2, 1, $urandom, 32'h0, 0, 0, 0);
        end

        // Enable held low in the delay slot; stray redirect ignored.
        step(1, 1, 0, 32'd0,        32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 1, 32'hBFC0_0040, 32'hBFC0_0004, 1, 1, 0);
        step(0, 0, 0, 32'd0,        32'hBFC0_0004, 1, 1, 0);
        step(0, 0, 1, 32'hBFC0_0100, 32'hBFC0_0004, 1, 1, 0);
        step(0, 0, 0, 32'd0,        32'hBFC0_0004, 1, 1, 0);
        step(0, 0, 0, 32'd0,        32'hBFC0_0004, 1, 1, 0);
        step(0, 1, 1, 32'hBFC0_0100, 32'hBFC0_0040, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0044, 0, 1, 0);

        // Reset in the delay slot discards the pending target.
        step(0, 1, 1, 32'hBFC0_0080, 32'hBFC0_0048, 1, 1, 0);
        step(1, 1, 0, 32'd0,        32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0004, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0008, 0, 1, 0);

        // Misaligned redirect target.
`ifdef PC_ALIGN_CHECK_EN
        flt_addr = 32'h0; flt_ds = 1'b0; flt_act = 1'b0; flt_flag = 1'b1;
`else
        flt_addr = 32'hBFC0_0010; flt_ds = 1'b0; flt_act = 1'b1; flt_flag = 1'b0;
`endif
        step(0, 1, 1, 32'hBFC0_0012, 32'hBFC0_000C, 1, 1, flt_flag);
        step(0, 1, 0, 32'd0,        flt_addr, flt_ds, flt_act, flt_flag);
        step(0, 1, 0, 32'd0,        flt_act ? 32'hBFC0_0014 : 32'h0, 0, flt_act, flt_flag);

        // Sequential wrap past the top of memory halts; link_address wraps.
        step(1, 1, 0, 32'd0,        32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 1, 32'hFFFF_FFF8, 32'hBFC0_0004, 1, 1, 0);
        step(0, 1, 0, 32'd0,        32'hFFFF_FFF8, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hFFFF_FFFC, 0, 1, 0);
        step(0, 1, 1, 32'hBFC0_0000, 32'h0000_0000, 0, 0, 0);

        // Reset wins over a low enable and leaves HALTED; enable low then holds.
        step(1, 0, 1, 32'hBFC0_0100, 32'hBFC0_0000, 0, 1, 0);
        step(0, 0, 1, 32'hBFC0_0100, 32'hBFC0_0000, 0, 1, 0);
        step(0, 1, 0, 32'd0,        32'hBFC0_0004, 0, 1, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        if (mon_idx != n_step) begin
            n_cmp++;
            n_bad++;
            $display("FAIL monitor_count: got %0d want %0d", mon_idx, n_step);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch_pc.md
MIPS_CPU_FETCH_PC -- requirements
Module: mips_cpu_fetch_pc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Port list (name, direction, width, meaning), one per line:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  advance enable; when low, all state SHALL hold.
- redirect_valid  in  1  the instruction currently at instr_address is a taken branch or jump.
- redirect_target  in  32  destination address for that taken branch or jump.
- instr_address  out  32  registered fetch address driven to instruction memory.
- delay_slot  out  1  high while the instruction at instr_address is a branch delay slot.
- link_address  out  32  combinational instr_address + 8, used for JAL/JALR/BxxAL.
- active  out  1  high while executing; low once halted.
- fault  out  1  sticky misaligned-target flag; only exists with REQ-017.

Function
REQ-003 States SHALL be RUN, DELAY and HALTED; state and all outputs are registered except link_address.
REQ-004 RUN, clk_enable=1, redirect_valid=0: instr_address SHALL become instr_address+4, and the state stays RUN.
REQ-005 RUN, clk_enable=1, redirect_valid=1: instr_address SHALL become instr_address+4, redirect_target SHALL be captured into a pending register, and the state SHALL become DELAY.
REQ-006 delay_slot SHALL equal 1 exactly while the state is DELAY.
REQ-007 DELAY, clk_enable=1: instr_address SHALL become the pending target and the state SHALL become RUN; redirect_valid in DELAY SHALL be ignored (a branch in a delay slot is not honoured).
REQ-008 Any edge that loads instr_address with 32'h00000000 (via +4 wrap from 32'hFFFFFFFC or via a pending target) SHALL also set the state to HALTED and active=0 on that same edge.
REQ-009 HALTED SHALL hold instr_address=0, active=0 and delay_slot=0 until reset, regardless of clk_enable or redirect_valid.
REQ-010 clk_enable=0 SHALL freeze state, instr_address and the pending register, including in DELAY.
REQ-011 Address arithmetic SHALL be 32-bit modulo 2^32; link_address wraps the same way.
REQ-012 instr_address SHALL change only on a rising clk edge, so it can feed a combinational ROM directly.

Reset
REQ-013 When reset=1 at a rising edge: instr_address=32'hBFC00000, state=RUN, active=1, delay_slot=0, fault=0, pending=0.
REQ-014 Reset SHALL take priority over clk_enable and redirect_valid.
REQ-015 Reset during DELAY SHALL discard the pending target.
REQ-016 Reset SHALL leave HALTED.

Configuration
REQ-017 Macro PC_ALIGN_CHECK_EN defined: a redirect accepted in RUN with redirect_target[1:0]!=0 SHALL set fault=1 (sticky until reset) and the state SHALL go to HALTED after the delay-slot fetch, with instr_address=0 and active=0.
REQ-018 Macro PC_ALIGN_CHECK_EN undefined: redirect_target[1:0] SHALL be cleared on capture, the fault port SHALL be absent, and no halt occurs.

Verification
REQ-019 Reset, then 3 enabled cycles with no redirect -> instr_address BFC00000, BFC00004, BFC00008, BFC0000C; active=1; delay_slot=0.
REQ-020 At BFC00000, redirect to BFC00010 -> next cycle BFC00004 with delay_slot=1, then BFC00010 with delay_slot=0; link_address at BFC00000 = BFC00008.
REQ-021 At BFC00010, redirect to 0 (jr $0) -> BFC00014 with delay_slot=1, then instr_address=0, active=0, and it holds for 10 more cycles despite redirects.
REQ-022 In DELAY, clk_enable=0 for 4 cycles, plus a redirect pulse to BFC00100 -> state frozen, pulse ignored, original target taken on re-enable.
REQ-023 Reset asserted while in DELAY -> instr_address=BFC00000, delay_slot=0, pending target never fetched.
REQ-024 With PC_ALIGN_CHECK_EN: redirect to BFC00012 -> fault=1 and halt after the delay slot. Without the macro: fetch BFC00010.
